pad_ring_seq: RTL and testbench
===============================

PAD_RING_SEQ -- requirements
Module: pad_ring_seq

Interface
REQ-001 SHALL have parameter NGRP, default 4, number of pad supply/enable groups sequenced (2..16).
REQ-002 SHALL have parameter DLY_W, default 8, width of the per-step delay setting.
REQ-003 SHALL have port CLK  input  1  single clock for all state.
REQ-004 SHALL have port RESETn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port pwr_up  input  1  level request to power the pad ring up.
REQ-006 SHALL have port pwr_dn  input  1  level request to power the pad ring down.
REQ-007 SHALL have port step_dly  input  DLY_W  cycles between group steps, minus one; sampled at each step start.
REQ-008 SHALL have port pad_en  output  NGRP  per-group enable, thermometer code, bit 0 first on, last off.
REQ-009 SHALL have port pad_iso  output  1  core-to-pad isolation; high unless the ring is fully on.
REQ-010 SHALL have port ring_on  output  1  high only in state ON.
REQ-011 SHALL have port busy  output  1  high in states UP and DOWN.

Function
REQ-012 SHALL implement a four-state FSM: OFF, UP, ON, DOWN; all outputs SHALL be registered.
REQ-013 In OFF: pad_en=0, pad_iso=1, ring_on=0, busy=0.
REQ-014 OFF->UP when pwr_up=1 and pwr_dn=0; in the same edge pad_en bit 0 SHALL set and the delay counter SHALL load step_dly.
REQ-015 In UP the delay counter SHALL decrement each cycle; when it is 0 and pad_en is not all-ones, the next pad_en bit SHALL set and the counter SHALL reload step_dly.
REQ-016 Each group step SHALL therefore last exactly step_dly+1 cycles; step_dly=0 gives one group per cycle.
REQ-017 UP->ON when the counter is 0 and pad_en is all-ones; on entry to ON pad_iso SHALL fall and ring_on SHALL rise on the same edge.
REQ-018 ON->DOWN when pwr_dn=1; on that edge pad_iso SHALL rise and ring_on SHALL fall, and pad_en SHALL remain unchanged for one step_dly+1 interval before the highest bit clears.
REQ-019 In DOWN, after each counter expiry the highest set pad_en bit SHALL clear and the counter SHALL reload step_dly.
REQ-020 DOWN->OFF on the edge that clears pad_en bit 0.
REQ-021 pwr_dn=1 during UP SHALL abort: next state DOWN, counter reloads, already-enabled groups power down in reverse order from the current position.
REQ-022 pwr_up=1 during DOWN SHALL be ignored until OFF is reached; if still high in OFF, a new UP sequence SHALL start.
REQ-023 pwr_up and pwr_dn both high SHALL be treated as pwr_dn (down has priority in every state).
REQ-024 pwr_up in ON and pwr_dn in OFF SHALL have no effect.
REQ-025 pad_iso SHALL never be low while any pad_en bit is 0.
REQ-026 The delay counter SHALL be DLY_W bits, shall not wrap below 0, and shall hold 0 in OFF and ON.
REQ-027 pad_en SHALL only change by one bit per step and SHALL always be a valid thermometer code.

Reset
REQ-028 RESETn low SHALL immediately force state OFF, pad_en=0, pad_iso=1, ring_on=0, busy=0, counter=0, independent of CLK.
REQ-029 Reset assertion mid-UP or mid-DOWN SHALL drop all groups at once; after RESETn deasserts, the first action SHALL be on the second rising CLK edge at the earliest.
REQ-030 Release of RESETn SHALL be synchronous to CLK.

Verification
REQ-031 NGRP=4, step_dly=2, pwr_up pulse held: pad_en 0001,0011,0111,1111 at edges 1,4,7,10; pad_iso falls and ring_on rises at edge 13; busy high edges 1-12.
REQ-032 From ON, pwr_dn=1, step_dly=0: pad_iso=1 at edge 1; pad_en 0111,0011,0001,0000 at edges 2-5; OFF at edge 5; busy low after.
REQ-033 step_dly=3, pwr_dn asserted when pad_en=0011: DOWN entered next edge; pad_en 0001 after 4 cycles, 0000 after 8; ON never reached, pad_iso stays 1.
REQ-034 pwr_up and pwr_dn both high in OFF -> no change; both high in ON -> DOWN sequence as REQ-032.
REQ-035 RESETn pulsed low mid-UP (pad_en=0111) -> all outputs at reset values before next CLK edge; with pwr_up still high after release, a fresh sequence starts from 0001.
REQ-036 Assertion checks every cycle: pad_en is thermometer code, pad_iso=1 whenever pad_en != all-ones, at most one pad_en bit changes per cycle.

Source files
------------

// File: rtl/pad_ring_seq.sv
// -----------------------------------------------------------------------------
// pad_ring_seq
//
// Purpose
//   Sequences NGRP pad supply/enable groups on and off. Power-up enables the
//   groups one at a time (bit 0 first), with a programmable gap between steps.
//   Once every group is on, core-to-pad isolation is released. Power-down
//   raises isolation first and then disables the groups in reverse order.
//
// Ports
//   CLK        in   1      single clock for all state
//   RESETn     in   1      asynchronous active-low reset (release is
//                          synchronised to CLK internally)
//   pwr_up     in   1      level request to power the ring up
//   pwr_dn     in   1      level request to power the ring down (wins over
//                          pwr_up in every state)
//   step_dly   in   DLY_W  cycles between group steps minus one, sampled at
//                          the start of every step
//   pad_en     out  NGRP   per-group enable, thermometer code
//   pad_iso    out  1      isolation, high unless the ring is fully on
//   ring_on    out  1      high only in ON
//   busy       out  1      high while sequencing (UP or DOWN)
//   state_dbg  out  2      current FSM state (OFF=0, UP=1, ON=2, DOWN=3)
//
// All outputs come straight from flops. They are derived from the next state
// so they always agree with the state register.
// -----------------------------------------------------------------------------
module pad_ring_seq #(
  parameter int NGRP  = 4,
  parameter int DLY_W = 8
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             pwr_up,
  input  logic             pwr_dn,
  input  logic [DLY_W-1:0] step_dly,
  output logic [NGRP-1:0]  pad_en,
  output logic             pad_iso,
  output logic             ring_on,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_UP   = 2'd1,
    ST_ON   = 2'd2,
    ST_DOWN = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Reset synchroniser: assertion reaches the sequencer immediately, while
  // release passes through two flops. The sequencer therefore cannot act
  // before the third rising edge after RESETn goes high.
  // ---------------------------------------------------------------------------
  logic [1:0] rst_sync;
  logic       rst_n_int;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_n_int = rst_sync[1];

  // ---------------------------------------------------------------------------
  // Sequencer state
  // ---------------------------------------------------------------------------
  state_t            state;
  state_t            state_n;
  logic [DLY_W-1:0]  cnt;
  logic [DLY_W-1:0]  cnt_n;
  logic [NGRP-1:0]   en_n;
  logic              iso_n;
  logic              on_n;
  logic              busy_n;

  logic              cnt_zero;
  logic              all_on;
  logic [NGRP-1:0]   en_grow;
  logic [NGRP-1:0]   en_shrink;

  assign cnt_zero  = (cnt == '0);
  assign all_on    = &pad_en;
  // One more group on, or the highest group off. Both keep a thermometer code.
  assign en_grow   = {pad_en[NGRP-2:0], 1'b1};
  assign en_shrink = pad_en >> 1;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    en_n    = pad_en;

    unique case (state)
      ST_OFF: begin
        cnt_n = '0;
        // pwr_dn alone, or both requests together, leave the ring off.
        if (pwr_up && !pwr_dn) begin
          state_n = ST_UP;
          en_n    = {{(NGRP-1){1'b0}}, 1'b1};
          cnt_n   = step_dly;
        end
      end

      ST_UP: begin
        if (pwr_dn) begin
          // Abort: keep the groups already on and walk them back down,
          // starting with a full step interval.
          state_n = ST_DOWN;
          cnt_n   = step_dly;
        end else if (!cnt_zero) begin
          cnt_n = cnt - DLY_W'(1);
        end else if (!all_on) begin
          en_n  = en_grow;
          cnt_n = step_dly;
        end else begin
          state_n = ST_ON;
          cnt_n   = '0;
        end
      end

      ST_ON: begin
        cnt_n = '0;
        // pwr_up is irrelevant here. pwr_dn raises isolation on this edge;
        // the groups stay on for one full step before the first one drops.
        if (pwr_dn) begin
          state_n = ST_DOWN;
          cnt_n   = step_dly;
        end
      end

      ST_DOWN: begin
        // Requests are ignored until the ring reaches OFF.
        if (!cnt_zero) begin
          cnt_n = cnt - DLY_W'(1);
        end else begin
          en_n = en_shrink;
          if (en_shrink == '0) begin
            state_n = ST_OFF;
            cnt_n   = '0;
          end else begin
            cnt_n = step_dly;
          end
        end
      end

      default: begin
        state_n = ST_OFF;
        cnt_n   = '0;
        en_n    = '0;
      end
    endcase

    // Status outputs follow the next state so they switch on the same edge
    // as the state change. Isolation is released only in ON, where every
    // group is on by construction.
    iso_n  = (state_n != ST_ON);
    on_n   = (state_n == ST_ON);
    busy_n = (state_n == ST_UP) || (state_n == ST_DOWN);
  end

  always_ff @(posedge CLK or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state   <= ST_OFF;
      cnt     <= '0;
      pad_en  <= '0;
      pad_iso <= 1'b1;
      ring_on <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      pad_en  <= en_n;
      pad_iso <= iso_n;
      ring_on <= on_n;
      busy    <= busy_n;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_pad_ring_seq.sv
// -----------------------------------------------------------------------------
// tb_pad_ring_seq
//
// Directed bench for pad_ring_seq with NGRP=4. Expected output words
// {pad_en, pad_iso, ring_on, busy} are pushed into exp_q before each clock
// edge and popped and compared once the edge has produced the DUT outputs.
// A negedge monitor checks the ring invariants every cycle.
// -----------------------------------------------------------------------------
module tb_pad_ring_seq;

  localparam int NGRP  = 4;
  localparam int DLY_W = 8;
  localparam int W     = NGRP + 3;

  // clock / reset and DUT signals
  logic             CLK;
  logic             RESETn;
  logic             pwr_up;
  logic             pwr_dn;
  logic [DLY_W-1:0] step_dly;
  logic [NGRP-1:0]  pad_en;
  logic             pad_iso;
  logic             ring_on;
  logic             busy;
  logic [1:0]       state_dbg;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];

  pad_ring_seq #(
    .NGRP  (NGRP),
    .DLY_W (DLY_W)
  ) dut (
    .CLK       (CLK),
    .RESETn    (RESETn),
    .pwr_up    (pwr_up),
    .pwr_dn    (pwr_dn),
    .step_dly  (step_dly),
    .pad_en    (pad_en),
    .pad_iso   (pad_iso),
    .ring_on   (ring_on),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // ---------------------------------------------------------------------------
  // Clock and watchdog
  // ---------------------------------------------------------------------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Scoreboard helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NGRP-1:0] thermo(input int g);
    logic [NGRP:0] t;
    t = (({{NGRP{1'b0}}, 1'b1}) << g) - 1'b1;
    return t[NGRP-1:0];
  endfunction

  function automatic logic is_thermo(input logic [NGRP-1:0] x);
    logic [NGRP-1:0] t;
    t = x + 1'b1;
    return ((t & x) == '0);
  endfunction

  // Push the expectation for the coming edge, let the edge happen, then pop
  // and compare against what the DUT drives 1 ns later.
  task automatic expect_edge(input string tag, input logic [NGRP-1:0] en,
                             input logic iso, input logic on, input logic bsy);
    logic [W-1:0] e;
    exp_q.push_back({en, iso, on, bsy});
    @(posedge CLK);
    #1;
    e = exp_q.pop_front();
    check(tag, {9'd0, pad_en, pad_iso, ring_on, busy}, {9'd0, e});
  endtask

  task automatic hold(input string tag, input int n, input logic [NGRP-1:0] en,
                      input logic iso, input logic on, input logic bsy);
    for (int i = 0; i < n; i++) expect_edge(tag, en, iso, on, bsy);
  endtask

  // Power-up edges k0..k1 for step delay d. Each step lasts d+1 cycles, the
  // last group goes on at edge 3(d+1)+1 and ON is entered at edge 4(d+1)+1.
  task automatic ramp_up(input int d, input int k0, input int k1);
    int g;
    int last;
    logic on;
    last = NGRP * (d + 1) + 1;
    for (int k = k0; k <= k1; k++) begin
      g  = (k - 1) / (d + 1) + 1;
      if (g > NGRP) g = NGRP;
      on = (k == last);
      expect_edge($sformatf("up_d%0d_k%0d", d, k), thermo(g), !on, on, !on);
    end
  endtask

  // Power-down from g0 groups for step delay d: edge 1 enters DOWN with the
  // groups unchanged, then one group drops every d+1 edges. pwr_dn is released
  // after edge 1 and pwr_up is driven to up_during for the rest of the ramp.
  task automatic ramp_down(input int d, input int g0, input logic up_during);
    int g;
    int last;
    last = g0 * (d + 1) + 1;
    for (int k = 1; k <= last; k++) begin
      g = g0 - (k - 1) / (d + 1);
      expect_edge($sformatf("dn_d%0d_k%0d", d, k), thermo(g), 1'b1, 1'b0, (g > 0));
      if (k == 1) begin
        pwr_dn = 1'b0;
        pwr_up = up_during;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Per-cycle invariants
  // ---------------------------------------------------------------------------
  logic [NGRP-1:0] prev_en;
  logic            prev_valid = 1'b0;

  always @(negedge CLK) begin
    if (!RESETn) begin
      prev_valid = 1'b0;
    end else begin
      check("inv_thermo", {15'd0, is_thermo(pad_en)}, 16'd1);
      if (pad_en != {NGRP{1'b1}}) check("inv_iso", {15'd0, pad_iso}, 16'd1);
      if (prev_valid) check("inv_one_bit", {15'd0, ($countones(pad_en ^ prev_en) <= 1)}, 16'd1);
      prev_en    = pad_en;
      prev_valid = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic started;

    RESETn   = 1'b0;
    pwr_up   = 1'b0;
    pwr_dn   = 1'b0;
    step_dly = 8'd2;

    // reset state
    repeat (2) @(posedge CLK);
    #1;
    check("reset_state", {9'd0, pad_en, pad_iso, ring_on, busy}, {9'd0, 4'b0000, 3'b100});
    RESETn = 1'b1;
    hold("idle_after_reset", 3, 4'b0000, 1'b1, 1'b0, 1'b0);

    // power up with step_dly=2, request held; pwr_up in ON has no effect
    pwr_up = 1'b1;
    ramp_up(2, 1, 13);
    hold("on_pwr_up_held", 2, 4'b1111, 1'b0, 1'b1, 1'b0);

    // power down with step_dly=0
    pwr_up   = 1'b0;
    pwr_dn   = 1'b1;
    step_dly = 8'd0;
    ramp_down(0, 4, 1'b0);

    // pwr_dn alone and both requests in OFF: no change
    pwr_dn = 1'b1;
    hold("off_pwr_dn", 2, 4'b0000, 1'b1, 1'b0, 1'b0);
    pwr_up = 1'b1;
    hold("off_both", 2, 4'b0000, 1'b1, 1'b0, 1'b0);
    pwr_up = 1'b0;
    pwr_dn = 1'b0;

    // fast ramp up, then both requests in ON take the down path
    pwr_up = 1'b1;
    ramp_up(0, 1, 5);
    pwr_dn = 1'b1;
    ramp_down(0, 4, 1'b0);

    // abort mid-UP at pad_en=0011 with step_dly=3; pwr_up held through DOWN
    // is ignored until OFF, then starts a fresh ramp
    step_dly = 8'd3;
    pwr_up   = 1'b1;
    ramp_up(3, 1, 5);
    pwr_dn = 1'b1;
    ramp_down(3, 2, 1'b1);
    ramp_up(3, 1, 17);

    // back down, then async reset in the middle of a ramp at pad_en=0111
    pwr_up   = 1'b0;
    pwr_dn   = 1'b1;
    step_dly = 8'd0;
    ramp_down(0, 4, 1'b0);
    step_dly = 8'd2;
    pwr_up   = 1'b1;
    ramp_up(2, 1, 7);
    #2 RESETn = 1'b0;
    #1 check("async_reset", {9'd0, pad_en, pad_iso, ring_on, busy}, {9'd0, 4'b0000, 3'b100});
    #3 RESETn = 1'b1;

    // nothing may happen on the first edge after release
    expect_edge("rst_release_edge1", 4'b0000, 1'b1, 1'b0, 1'b0);
    started = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!started) begin
        @(posedge CLK);
        #1;
        if (pad_en != '0) started = 1'b1;
      end
    end
    check("restart_bound", {15'd0, started}, 16'd1);
    check("restart_first", {9'd0, pad_en, pad_iso, ring_on, busy}, {9'd0, 4'b0001, 3'b101});
    ramp_up(2, 2, 13);
    pwr_up = 1'b0;
    hold("final_on", 2, 4'b1111, 1'b0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
